// File: rtl/hash_pkg.sv
// Shared constants, entry types and the CDB snoop helper for the hash
// reservation station.
package hash_pkg;

    localparam int HASH_RS_DEPTH = 4;
    localparam int W             = 8;
    localparam int IDW           = 4;

    typedef struct packed {
        logic           rdy;
        logic [IDW-1:0] tag;
        logic [W-1:0]   val;
    } src_t;

    typedef struct packed {
        logic           valid;
        logic [W-1:0]   operand;
        src_t [1:0]     src;
        logic [W-1:0]   wbs;
        logic [W-1:0]   flags;
        logic [IDW-1:0] robid;
    } rs_entry_t;

    // A pending source captures the broadcast when the full tag matches.
    function automatic src_t cdb_snoop(src_t s, logic hit_v, logic [IDW-1:0] id,
                                       logic [W-1:0] val);
        src_t r;
        r = s;
        if (!s.rdy && hit_v && (s.tag == id)) begin
            r.rdy = 1'b1;
            r.val = val;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority picker over the per-entry ready vector.
module rs_pick #(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready,
    output logic             found,
    output logic [IW-1:0]    index
);

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                found = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/hash_rs.sv
// Reservation station feeding the hash FU: collapsing queue, CDB wakeup,
// oldest-ready dispatch with a registered FU-side output stage.
module hash_rs
    import hash_pkg::src_t, hash_pkg::rs_entry_t, hash_pkg::cdb_snoop;
#(
    parameter int DEPTH = hash_pkg::HASH_RS_DEPTH,
    parameter int W     = hash_pkg::W,
    parameter int IDW   = hash_pkg::IDW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       issue_valid,
    input  logic [W-1:0]               issue_operand,
    input  logic [1:0]                 issue_src_rdy,
    input  logic [2*IDW-1:0]           issue_src_tag,
    input  logic [2*W-1:0]             issue_src_val,
    input  logic [W-1:0]               issue_wbs,
    input  logic [W-1:0]               issue_flags,
    input  logic [IDW-1:0]             issue_robid,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       cdb_valid,
    input  logic [IDW-1:0]             cdb_id,
    input  logic [W-1:0]               cdb_val,
    input  logic                       fu_busy,
    output logic                       input_transmit,
    output logic [W-1:0]               operand,
    output logic [2*W-1:0]             depvals,
    output logic [W-1:0]               wbs,
    output logic [W-1:0]               flags,
    output logic [IDW-1:0]             robid
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    rs_entry_t        ent     [DEPTH];
    rs_entry_t        ent_w   [DEPTH];
    rs_entry_t        ent_up  [DEPTH];
    rs_entry_t        ent_n   [DEPTH];
    rs_entry_t        new_ent;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    wr_idx;
    logic [DEPTH-1:0] ready_vec;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             issue_acc;
    logic             dispatch;

    assign full      = (cnt == CW'(DEPTH));
    assign count     = cnt;
    assign issue_acc = issue_valid && !full && !flush;
    // The strobe gap lets the FU raise busy before the next pick is considered.
    assign dispatch  = pick_found && !fu_busy && !input_transmit;
    assign wr_idx    = cnt - CW'(dispatch);
    assign cnt_n     = cnt + CW'(issue_acc) - CW'(dispatch);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready_vec[i] = ent[i].valid && ent[i].src[0].rdy && ent[i].src[1].rdy;
        end
    end

    rs_pick #(.DEPTH(DEPTH), .IW(IW)) u_pick (
        .ready (ready_vec),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.operand = issue_operand;
        new_ent.wbs     = issue_wbs;
        new_ent.flags   = issue_flags;
        new_ent.robid   = issue_robid;
        for (int s = 0; s < 2; s++) begin
            new_ent.src[s] = cdb_snoop({issue_src_rdy[s], issue_src_tag[s*IDW +: IDW],
                                        issue_src_val[s*W +: W]},
                                       cdb_valid, cdb_id, cdb_val);
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_w[i] = ent[i];
            if (ent[i].valid) begin
                for (int s = 0; s < 2; s++) begin
                    ent_w[i].src[s] = cdb_snoop(ent[i].src[s], cdb_valid, cdb_id, cdb_val);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_up[i] = ent_w[i + 1];
        end
        ent_up[DEPTH-1] = '0;
    end

    // Collapse above the dispatched slot, then drop the new entry on the tail.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_n[i] = ent_w[i];
            if (dispatch && (i >= int'(pick_idx))) begin
                ent_n[i] = ent_up[i];
            end
            if (issue_acc && (i == int'(wr_idx))) begin
                ent_n[i] = new_ent;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            cnt            <= '0;
            input_transmit <= 1'b0;
            operand        <= '0;
            depvals        <= '0;
            wbs            <= '0;
            flags          <= '0;
            robid          <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            cnt            <= '0;
            input_transmit <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= ent_n[i];
            end
            cnt            <= cnt_n;
            input_transmit <= dispatch;
            if (dispatch) begin
                operand <= ent[pick_idx].operand;
                depvals <= {ent[pick_idx].src[1].val, ent[pick_idx].src[0].val};
                wbs     <= ent[pick_idx].wbs;
                flags   <= ent[pick_idx].flags;
                robid   <= ent[pick_idx].robid;
            end
        end
    end

endmodule

// File: tb/tb_hash_rs.sv
// Directed bench for hash_rs: stimulus pushes expected dispatches into a
// queue, a negedge monitor pops and compares on every input_transmit.
module tb_hash_rs;

    typedef struct packed {
        logic [3:0] robid;
        logic [7:0] op;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] wbs;
        logic [7:0] flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, issue_valid;
    logic [7:0]  issue_operand, issue_wbs, issue_flags;
    logic [1:0]  issue_src_rdy;
    logic [7:0]  issue_src_tag;
    logic [15:0] issue_src_val;
    logic [3:0]  issue_robid;
    logic        full;
    logic [2:0]  count;
    logic        cdb_valid;
    logic [3:0]  cdb_id;
    logic [7:0]  cdb_val;
    logic        fu_busy;
    logic        input_transmit;
    logic [7:0]  operand, wbs, flags;
    logic [15:0] depvals;
    logic [3:0]  robid;

    int   nvec = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   last_strobe = -100;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    hash_rs dut (
        .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
        .issue_operand(issue_operand), .issue_src_rdy(issue_src_rdy),
        .issue_src_tag(issue_src_tag), .issue_src_val(issue_src_val),
        .issue_wbs(issue_wbs), .issue_flags(issue_flags), .issue_robid(issue_robid),
        .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_id(cdb_id),
        .cdb_val(cdb_val), .fu_busy(fu_busy), .input_transmit(input_transmit),
        .operand(operand), .depvals(depvals), .wbs(wbs), .flags(flags), .robid(robid)
    );

    function automatic exp_t mk(input logic [3:0] rid, input logic [7:0] op,
                                input logic [7:0] d0, input logic [7:0] d1);
        exp_t e;
        e.robid = rid;
        e.op    = op;
        e.d0    = d0;
        e.d1    = d1;
        e.wbs   = op ^ 8'hFF;
        e.flags = op + 8'h11;
        return e;
    endfunction

    always @(negedge clk) begin
        if (input_transmit) begin
            exp_t act;
            exp_t e;
            nvec++;
            if (cyc - last_strobe < 2) begin
                nerr++;
                $display("FAIL strobe_spacing gap=%0d required>=2", cyc - last_strobe);
            end
            last_strobe = cyc;
            act = {robid, operand, depvals[7:0], depvals[15:8], wbs, flags};
            nvec++;
            if (q.size() == 0) begin
                nerr++;
                $display("FAIL unexpected_dispatch robid=%0h (no dispatch expected)", robid);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    nerr++;
                    $display("FAIL dispatch actual={rid %0h op %0h d0 %0h d1 %0h wbs %0h fl %0h} expected={rid %0h op %0h d0 %0h d1 %0h wbs %0h fl %0h}",
                             act.robid, act.op, act.d0, act.d1, act.wbs, act.flags,
                             e.robid, e.op, e.d0, e.d1, e.wbs, e.flags);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive_issue(input logic [3:0] rid, input logic [1:0] rdy,
                               input logic [3:0] t0, input logic [3:0] t1,
                               input logic [7:0] v0, input logic [7:0] v1,
                               input logic [7:0] op);
        issue_valid   = 1'b1;
        issue_robid   = rid;
        issue_src_rdy = rdy;
        issue_src_tag = {t1, t0};
        issue_src_val = {v1, v0};
        issue_operand = op;
        issue_wbs     = op ^ 8'hFF;
        issue_flags   = op + 8'h11;
    endtask

    task automatic issue(input logic [3:0] rid, input logic [1:0] rdy,
                         input logic [3:0] t0, input logic [3:0] t1,
                         input logic [7:0] v0, input logic [7:0] v1,
                         input logic [7:0] op);
        drive_issue(rid, rdy, t0, t1, v0, v1, op);
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic broadcast(input logic [3:0] id, input logic [7:0] val);
        cdb_valid = 1'b1;
        cdb_id    = id;
        cdb_val   = val;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_transmit"}, 32'(input_transmit), 32'h0);
        check({tag, "_operand"},  32'(operand), 32'h0);
        check({tag, "_depvals"},  32'(depvals), 32'h0);
        check({tag, "_wbs"},      32'(wbs), 32'h0);
        check({tag, "_flags"},    32'(flags), 32'h0);
        check({tag, "_robid"},    32'(robid), 32'h0);
        check({tag, "_count"},    32'(count), 32'h0);
        check({tag, "_full"},     32'(full), 32'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_operand = '0;
        issue_src_rdy = '0; issue_src_tag = '0; issue_src_val = '0;
        issue_wbs = '0; issue_flags = '0; issue_robid = '0;
        cdb_valid = 1'b0; cdb_id = '0; cdb_val = '0; fu_busy = 1'b0;
        wait_cycles(2);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // basic dispatch
        q.push_back(mk(4'd1, 8'h55, 8'h12, 8'h34));
        issue(4'd1, 2'b11, 4'd0, 4'd0, 8'h12, 8'h34, 8'h55);
        wait_cycles(3);
        @(negedge clk);
        check("basic_count", 32'(count), 32'h0);

        // back-to-back: second issue lands on the same edge as the first dispatch
        q.push_back(mk(4'd6, 8'h10, 8'h01, 8'h02));
        issue(4'd6, 2'b11, 4'd0, 4'd0, 8'h01, 8'h02, 8'h10);
        q.push_back(mk(4'd7, 8'h20, 8'h03, 8'h04));
        issue(4'd7, 2'b11, 4'd0, 4'd0, 8'h03, 8'h04, 8'h20);
        @(negedge clk);
        check("issue_dispatch_count", 32'(count), 32'h1);
        wait_cycles(4);
        check("b2b_drain_count", 32'(count), 32'h0);

        // CDB wakeup
        issue(4'd2, 2'b10, 4'd5, 4'd0, 8'hEE, 8'h22, 8'h30);
        wait_cycles(3);
        @(negedge clk);
        check("wakeup_wait_count", 32'(count), 32'h1);
        q.push_back(mk(4'd2, 8'h30, 8'hA5, 8'h22));
        broadcast(4'd5, 8'hA5);
        wait_cycles(3);
        check("wakeup_drain_count", 32'(count), 32'h0);

        // same-cycle CDB capture on both sources
        q.push_back(mk(4'd3, 8'h40, 8'hFF, 8'hFF));
        cdb_valid = 1'b1; cdb_id = 4'd7; cdb_val = 8'hFF;
        issue(4'd3, 2'b00, 4'd7, 4'd7, 8'h00, 8'h00, 8'h40);
        cdb_valid = 1'b0;
        wait_cycles(4);
        check("capture_count", 32'(count), 32'h0);

        // fill under busy, fifth issue ignored, then ordered drain
        fu_busy = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            q.push_back(mk(4'(r), 8'(8'h50 + r), 8'(8'h10 * r), 8'(8'h10 * r + 1)));
            issue(4'(r), 2'b11, 4'd0, 4'd0, 8'(8'h10 * r), 8'(8'h10 * r + 1), 8'(8'h50 + r));
        end
        @(negedge clk);
        check("fill_count", 32'(count), 32'h4);
        check("fill_full", 32'(full), 32'h1);
        issue(4'd5, 2'b11, 4'd0, 4'd0, 8'h77, 8'h78, 8'h5F);
        check("fifth_ignored_count", 32'(count), 32'h4);
        fu_busy = 1'b0;
        wait_cycles(10);
        check("fill_drain_count", 32'(count), 32'h0);
        check("fill_drain_full", 32'(full), 32'h0);

        // out-of-order readiness, tag 0 is a real tag
        issue(4'd3, 2'b00, 4'd9, 4'd0, 8'hEE, 8'hEE, 8'h60);
        q.push_back(mk(4'd4, 8'h70, 8'h44, 8'h45));
        issue(4'd4, 2'b11, 4'd0, 4'd0, 8'h44, 8'h45, 8'h70);
        wait_cycles(4);
        check("ooo_wait_count", 32'(count), 32'h1);
        broadcast(4'd0, 8'h0A);
        wait_cycles(2);
        check("ooo_half_ready_count", 32'(count), 32'h1);
        q.push_back(mk(4'd3, 8'h60, 8'h99, 8'h0A));
        broadcast(4'd9, 8'h99);
        wait_cycles(4);
        check("ooo_drain_count", 32'(count), 32'h0);

        // flush with concurrent issue
        fu_busy = 1'b1;
        for (int r = 8; r <= 10; r++) begin
            issue(4'(r), 2'b11, 4'd0, 4'd0, 8'(r), 8'(r), 8'(r));
        end
        @(negedge clk);
        check("preflush_count", 32'(count), 32'h3);
        flush = 1'b1;
        drive_issue(4'd11, 2'b11, 4'd0, 4'd0, 8'h0B, 8'h0B, 8'h0B);
        tick();
        flush = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk);
        check("flush_count", 32'(count), 32'h0);
        check("flush_transmit", 32'(input_transmit), 32'h0);
        check("flush_full", 32'(full), 32'h0);
        fu_busy = 1'b0;
        wait_cycles(8);
        check("postflush_count", 32'(count), 32'h0);

        // reset mid-operation clears the output stage too
        fu_busy = 1'b1;
        issue(4'd12, 2'b11, 4'd0, 4'd0, 8'hC1, 8'hC2, 8'hC3);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        fu_busy = 1'b0;
        wait_cycles(5);
        check("postreset_count", 32'(count), 32'h0);

        for (int i = 0; i < 50 && q.size() != 0; i++) tick();
        check("pending_dispatches", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
